// File: rtl/sram_arbiter_nx1.sv
// N-to-1 sram-like bus arbiter: round-robin (or fixed-priority) request selection,
// sticky lock on a stalled grant, and an in-order tag FIFO that routes s_data_ok back to its master.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).

module sram_arb_lane #(
  parameter int IDX = 0,
  parameter int PW  = 2
) (
  input  logic [PW-1:0] sel,
  input  logic [PW-1:0] head,
  input  logic          accept,
  input  logic          pop,
  output logic          addr_ok,
  output logic          data_ok
);
  assign addr_ok = accept && (sel  == PW'(IDX));
  assign data_ok = pop    && (head == PW'(IDX));
endmodule

module sram_arbiter_nx1 #(
  parameter int N_PORTS   = 3,
  parameter int MAX_OUTST = 4,
  parameter int DATA_W    = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_PORTS-1:0]        m_req,
  input  logic [N_PORTS-1:0]        m_wr,
  input  logic [2*N_PORTS-1:0]      m_size,
  input  logic [32*N_PORTS-1:0]     m_addr,
  input  logic [DATA_W*N_PORTS-1:0] m_wdata,
  output logic [N_PORTS-1:0]        m_addr_ok,
  output logic [N_PORTS-1:0]        m_data_ok,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      s_req,
  output logic                      s_wr,
  output logic [1:0]                s_size,
  output logic [31:0]               s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic                      s_addr_ok,
  input  logic                      s_data_ok,
  input  logic [DATA_W-1:0]         s_rdata
);
  localparam int PW = $clog2(N_PORTS);
  localparam int AW = $clog2(MAX_OUTST);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  logic [N_PORTS-1:0][1:0]        size_a;
  logic [N_PORTS-1:0][31:0]       addr_a;
  logic [N_PORTS-1:0][DATA_W-1:0] wdata_a;

  assign size_a  = m_size;
  assign addr_a  = m_addr;
  assign wdata_a = m_wdata;

  state_e        state_q, state_d;
  logic [PW-1:0] lock_sel_q, lock_sel_d;
  logic [PW-1:0] idle_sel, sel, head;
  logic          idle_vld, sel_req, accept, push, pop, full, empty;

  logic [MAX_OUTST-1:0][PW-1:0] tag_q, tag_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    idle_sel = '0;
    idle_vld = 1'b0;
    for (int i = N_PORTS-1; i >= 0; i--)
      if (m_req[i]) begin
        idle_sel = PW'(i);
        idle_vld = 1'b1;
      end
  end
`else
  logic [PW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [N_PORTS-1:0][PW-1:0]   cand;

  // cand[i] is the port i places after rr_ptr; scan downward so the nearest requester wins
  always_comb begin
    idle_sel = rr_ptr_q;
    idle_vld = 1'b0;
    cand     = '0;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      cand[i] = (int'(rr_ptr_q) + i >= N_PORTS) ? PW'(int'(rr_ptr_q) + i - N_PORTS)
                                                : PW'(int'(rr_ptr_q) + i);
      if (m_req[cand[i]]) begin
        idle_sel = cand[i];
        idle_vld = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept)
      rr_ptr_d = (sel == PW'(N_PORTS-1)) ? '0 : sel + PW'(1);
  end
`endif

  assign sel     = (state_q == LOCKED) ? lock_sel_q : idle_sel;
  assign sel_req = (state_q == LOCKED) ? m_req[lock_sel_q] : idle_vld;

  // reset gates the request combinationally so nothing leaks out while resetn is low
  assign s_req   = resetn && sel_req && !full;
  assign accept  = s_req && s_addr_ok;
  assign s_wr    = m_wr[sel];
  assign s_size  = size_a[sel];
  assign s_addr  = addr_a[sel];
  assign s_wdata = wdata_a[sel];
  assign m_rdata = s_rdata;

  // a winner that is not taken this cycle (slave stall or full FIFO) keeps the bus
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      IDLE:
        if (idle_vld && !accept) begin
          state_d    = LOCKED;
          lock_sel_d = idle_sel;
        end
      LOCKED:
        if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign full  = (cnt_q == CW'(MAX_OUTST));
  assign empty = (cnt_q == '0);
  assign push  = accept;
  assign pop   = s_data_ok && !empty;
  assign head  = tag_q[rd_ptr_q];

  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      tag_d[wr_ptr_q] = sel;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_lane
    sram_arb_lane #(.IDX(g), .PW(PW)) u_lane (
      .sel     (sel),
      .head    (head),
      .accept  (accept),
      .pop     (pop),
      .addr_ok (m_addr_ok[g]),
      .data_ok (m_data_ok[g])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter_nx1.sv
// Directed bench for sram_arbiter_nx1: arbitration order, lock on stall,
// tag FIFO full/stall, in-order data return and reset behaviour.

module tb_sram_arbiter_nx1;
  localparam int N  = 3;
  localparam int MO = 4;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [N-1:0]           m_req, m_wr, m_addr_ok, m_data_ok;
  logic [N-1:0][1:0]      m_size;
  logic [N-1:0][31:0]     m_addr;
  logic [N-1:0][DW-1:0]   m_wdata;
  logic [DW-1:0]          m_rdata, s_wdata, s_rdata;
  logic                   s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]             s_size;
  logic [31:0]            s_addr;

  int checks = 0;
  int errors = 0;

`ifdef ARB_FIXED_PRIO_EN
  int ga [6] = '{0, 0, 0, 0, 0, 0};
`else
  int ga [6] = '{0, 1, 2, 0, 1, 2};
`endif

  always #5 clk = ~clk;

  sram_arbiter_nx1 #(.N_PORTS(N), .MAX_OUTST(MO), .DATA_W(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_size    (m_size),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok),
    .m_rdata   (m_rdata),
    .s_req     (s_req),
    .s_wr      (s_wr),
    .s_size    (s_size),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_addr_ok (s_addr_ok),
    .s_data_ok (s_data_ok),
    .s_rdata   (s_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn    = 1'b1;
    m_wr      = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i]  = 32'h1000 + 32'(16 * i);
      m_wdata[i] = 32'hD0 + 32'(i);
      m_size[i]  = 2'(i);
    end
    m_req     = 3'b111;
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    s_rdata   = '0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_s_req",     32'(s_req),     0);
    chk("rst_addr_ok",   32'(m_addr_ok), 0);
    chk("rst_data_ok",   32'(m_data_ok), 0);

    @(negedge clk);
    resetn = 1'b1; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    @(negedge clk);

    // all three masters request continuously; one return per cycle keeps the FIFO at one entry
    m_req = 3'b111; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      s_rdata = 32'h100 + 32'(k);
      #1;
      chk("rr_grant", 32'(m_addr_ok), 1 << ga[k]);
      chk("rr_addr",  s_addr,         32'h1000 + 32'(16 * ga[k]));
      if (k == 0) chk("rr_dok_empty", 32'(m_data_ok), 0);
      else begin
        chk("rr_dok",   32'(m_data_ok), 1 << ga[k-1]);
        chk("rr_rdata", m_rdata,        32'h100 + 32'(k));
      end
    end
    @(negedge clk);
    m_req = '0; #1;
    chk("rr_drain_dok", 32'(m_data_ok), 1 << ga[5]);
    chk("rr_drain_aok", 32'(m_addr_ok), 0);

    // master 1 stalled by slave, master 0 joins; bus stays on master 1 until taken
    @(negedge clk);
    s_data_ok = 1'b0; s_addr_ok = 1'b0; m_req = 3'b010; m_wr = 3'b010; #1;
    chk("lock_c0_sreq", 32'(s_req),     1);
    chk("lock_c0_addr", s_addr,         32'h1010);
    chk("lock_c0_wr",   32'(s_wr),      1);
    chk("lock_c0_size", 32'(s_size),    1);
    chk("lock_c0_aok",  32'(m_addr_ok), 0);
    @(negedge clk);
    m_req = 3'b011; #1;
    chk("lock_c1_addr", s_addr,         32'h1010);
    chk("lock_c1_aok",  32'(m_addr_ok), 0);
    @(negedge clk); #1;
    chk("lock_c2_addr", s_addr,         32'h1010);
    @(negedge clk);
    s_addr_ok = 1'b1; #1;
    chk("lock_acc_aok",  32'(m_addr_ok), 32'b010);
    chk("lock_acc_addr", s_addr,         32'h1010);
    @(negedge clk);
    m_wr = '0; #1;
    chk("lock_next_aok",  32'(m_addr_ok), 32'b001);
    chk("lock_next_addr", s_addr,         32'h1000);
    chk("lock_next_wr",   32'(s_wr),      0);
    @(negedge clk);
    m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h55; #1;
    chk("lock_ret1_dok",   32'(m_data_ok), 32'b010);
    chk("lock_ret1_rdata", m_rdata,        32'h55);
    @(negedge clk);
    s_rdata = 32'h66; #1;
    chk("lock_ret2_dok",   32'(m_data_ok), 32'b001);
    chk("lock_ret2_rdata", m_rdata,        32'h66);
    @(negedge clk); #1;
    chk("empty_dok", 32'(m_data_ok), 0);

    // fill the tag FIFO with no returns, then free one slot
    @(negedge clk);
    s_data_ok = 1'b0; m_req = 3'b001; s_addr_ok = 1'b1;
    for (int k = 0; k < MO; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("fill_aok", 32'(m_addr_ok), 32'b001);
    end
    @(negedge clk); #1;
    chk("full_sreq", 32'(s_req),     0);
    chk("full_aok",  32'(m_addr_ok), 0);
    @(negedge clk);
    s_data_ok = 1'b1; #1;
    chk("full_pop_sreq", 32'(s_req),     0);
    chk("full_pop_dok",  32'(m_data_ok), 32'b001);
    @(negedge clk);
    s_data_ok = 1'b0; #1;
    chk("resume_sreq", 32'(s_req),     1);
    chk("resume_aok",  32'(m_addr_ok), 32'b001);
    @(negedge clk);
    m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    for (int k = 0; k < MO; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("full_drain_dok", 32'(m_data_ok), 32'b001);
    end
    @(negedge clk); #1;
    chk("full_drained", 32'(m_data_ok), 0);

    // reads from ports 2, 0, 1 come back in order with their data
    @(negedge clk);
    s_data_ok = 1'b0; s_addr_ok = 1'b1; m_req = 3'b100; #1;
    chk("ord_g2", 32'(m_addr_ok), 32'b100);
    @(negedge clk);
    m_req = 3'b001; #1;
    chk("ord_g0", 32'(m_addr_ok), 32'b001);
    @(negedge clk);
    m_req = 3'b010; #1;
    chk("ord_g1", 32'(m_addr_ok), 32'b010);
    @(negedge clk);
    m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hA; #1;
    chk("ord_r2_dok",   32'(m_data_ok), 32'b100);
    chk("ord_r2_rdata", m_rdata,        32'hA);
    @(negedge clk);
    s_rdata = 32'hB; #1;
    chk("ord_r0_dok",   32'(m_data_ok), 32'b001);
    chk("ord_r0_rdata", m_rdata,        32'hB);
    @(negedge clk);
    s_rdata = 32'hC; #1;
    chk("ord_r1_dok",   32'(m_data_ok), 32'b010);
    chk("ord_r1_rdata", m_rdata,        32'hC);

    // three in flight, then reset
    @(negedge clk);
    s_data_ok = 1'b0; m_req = 3'b111; s_addr_ok = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0; s_data_ok = 1'b1; #1;
    chk("inrst_sreq", 32'(s_req),     0);
    chk("inrst_aok",  32'(m_addr_ok), 0);
    chk("inrst_dok",  32'(m_data_ok), 0);
    @(negedge clk);
    resetn = 1'b1; m_req = '0; s_addr_ok = 1'b0; #1;
    chk("postrst_dok0", 32'(m_data_ok), 0);
    @(negedge clk); #1;
    chk("postrst_dok1", 32'(m_data_ok), 0);
    @(negedge clk);
    s_data_ok = 1'b0; m_req = 3'b111; s_addr_ok = 1'b1; #1;
    chk("postrst_grant", 32'(m_addr_ok), 32'b001);
    @(negedge clk);
    m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b1; #1;
    chk("postrst_ret", 32'(m_data_ok), 32'b001);
    @(negedge clk); #1;
    chk("postrst_empty", 32'(m_data_ok), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_nx1.md
SRAM_ARBITER_NX1 -- requirements
Module: sram_arbiter_nx1

Interface
REQ-001 SHALL have parameter N_PORTS, default 3, number of upstream sram-like masters (2..8).
REQ-002 SHALL have parameter MAX_OUTST, default 4, in-flight transactions tracked (power of 2, 2..16).
REQ-003 SHALL have parameter DATA_W, default 32, width of wdata/rdata.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m_req / m_wr  input  N_PORTS  per-master request and write flag.
REQ-007 SHALL have ports m_size  input  2*N_PORTS, m_addr  input  32*N_PORTS, m_wdata  input  DATA_W*N_PORTS; slice i belongs to master i.
REQ-008 SHALL have ports m_addr_ok / m_data_ok  output  N_PORTS  per-master handshakes, and m_rdata  output  DATA_W  shared read data.
REQ-009 SHALL have ports s_req, s_wr  output  1; s_size  output  2; s_addr  output  32; s_wdata  output  DATA_W  to downstream slave.
REQ-010 SHALL have ports s_addr_ok, s_data_ok  input  1; s_rdata  input  DATA_W  from downstream slave.

Function
REQ-011 SHALL select one requesting master per cycle and drive its wr/size/addr/wdata onto s_*; s_req = selected m_req AND tag FIFO not full.
REQ-012 SHALL, in state IDLE, pick the winner by round-robin starting at pointer rr_ptr; if the winner's request is not accepted (s_addr_ok=0), enter LOCKED.
REQ-013 SHALL, in state LOCKED, hold the same selection regardless of other requests until s_req && s_addr_ok, then return to IDLE.
REQ-014 SHALL assert m_addr_ok[k] = s_req && s_addr_ok && selected==k, combinationally; all other m_addr_ok bits 0.
REQ-015 SHALL, on acceptance from port k, set rr_ptr = (k+1) mod N_PORTS the next cycle.
REQ-016 SHALL push index k into an in-order tag FIFO (depth MAX_OUTST) on every accepted request.
REQ-017 SHALL, on s_data_ok, assert m_data_ok[head] for that cycle only, pop the FIFO, and drive m_rdata = s_rdata (combinational, zero latency).
REQ-018 SHALL hold s_req=0 while FIFO count == MAX_OUTST; push-and-pop in the same cycle at full is not allowed (stall takes precedence).
REQ-019 SHALL allow simultaneous push and pop when not full; count unchanged, pointers both advance, modulo MAX_OUTST wrap.
REQ-020 SHALL ignore s_data_ok when FIFO empty (no m_data_ok asserted, count stays 0).
REQ-021 SHALL keep count width clog2(MAX_OUTST)+1 so full and empty are distinct.

Reset
REQ-022 SHALL, on resetn=0, asynchronously set state=IDLE, rr_ptr=0, FIFO pointers and count=0.
REQ-023 SHALL drive all m_addr_ok, m_data_ok, s_req to 0 while resetn=0; in-flight transactions are discarded and late s_data_ok after reset treated per REQ-020.

Configuration
REQ-024 SHALL support macro ARB_FIXED_PRIO_EN: when defined, IDLE selection is fixed priority (lowest index wins) and rr_ptr is not implemented; when undefined, round-robin per REQ-012/015.

Verification
REQ-025 SHALL verify: masters 0,1,2 all request continuously, slave addr_ok=1 -> grants 0,1,2,0,1,2 in consecutive cycles (fixed-prio build: 0 every cycle).
REQ-026 SHALL verify: master 1 requests, s_addr_ok=0 for 3 cycles, master 0 requests at cycle 1 -> s_addr stays master 1's address until accepted, master 0 granted next.
REQ-027 SHALL verify: MAX_OUTST=4, 4 reads accepted, no s_data_ok -> 5th request sees s_req=0; one s_data_ok -> s_req reasserted next cycle.
REQ-028 SHALL verify: reads from ports 2,0,1 accepted, then s_data_ok with s_rdata 0xA, 0xB, 0xC -> m_data_ok pulses on ports 2,0,1 with m_rdata 0xA, 0xB, 0xC.
REQ-029 SHALL verify: resetn pulled low with 3 in flight -> outputs 0 immediately; after release, spurious s_data_ok produces no m_data_ok and count stays 0.
